// File: rtl/adc_reg_sequencer.sv
// Table-driven SPI register sequencer: writes each table entry to the ADC,
// reads it back, verifies it with bounded retries and reports done or error.
module adc_reg_sequencer #(
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int NUM_REGS        = 8,
    parameter int MAX_RETRY       = 3,
    parameter int GAP_CYCLES      = 16,
    parameter int BUSY_TO         = 1024
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               i_cfg_start,
    output logic                                               o_cfg_go,
    output logic                                               o_cfg_done,
    output logic                                               o_cfg_err,
    output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] o_tbl_addr,
    input  logic [MOSI_DATA_WIDTH-1:0]                         i_tbl_entry,
    output logic                                               o_spi_wr_cmd,
    output logic                                               o_spi_rd_cmd,
    output logic [MOSI_DATA_WIDTH-1:0]                         o_spi_wr_data,
    input  logic [MISO_DATA_WIDTH:0]                           i_spi_rd_data,
    input  logic                                               i_spi_busy
);
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TO) ? GAP_CYCLES : BUSY_TO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR_CMD, S_WR_WAIT, S_GAP_W, S_RD_CMD,
        S_RD_WAIT, S_CHECK, S_NEXT, S_DONE, S_FAIL
    } state_t;

    state_t                     r_state, w_state_n;
    logic                       r_start_q, r_start_qq;
    logic [CNT_W-1:0]           r_cnt, w_cnt_n;
    logic                       r_seen_busy, w_seen_n;
    logic [ADDR_W-1:0]          r_addr, w_addr_n;
    logic [RETRY_W-1:0]         r_retry, w_retry_n;
    logic [MOSI_DATA_WIDTH-1:0] r_entry, w_entry_n;
    logic [MISO_DATA_WIDTH-1:0] r_rd_data, w_rd_data_n;
    logic                       r_go, w_go_n;
    logic                       r_done, w_done_n;
    logic                       r_err, w_err_n;
    logic                       r_wr_cmd, w_wr_cmd_n;
    logic                       r_rd_cmd, w_rd_cmd_n;
    logic [MOSI_DATA_WIDTH-1:0] r_wr_data, w_wr_data_n;

    logic w_start_edge;
    logic w_gap_end;
    logic w_to_end;
    logic w_match;
    logic w_last;
    logic w_unused_rd_msb;

    // Start flops reset high so a level held through reset never looks like an edge.
    assign w_start_edge    = r_start_q & ~r_start_qq;
    assign w_gap_end       = (int'(r_cnt) >= GAP_CYCLES - 1);
    assign w_to_end        = (int'(r_cnt) >= BUSY_TO - 1);
    assign w_match         = (r_rd_data == r_entry[MISO_DATA_WIDTH-1:0]);
    assign w_last          = (r_addr == ADDR_W'(NUM_REGS - 1));
    assign w_unused_rd_msb = i_spi_rd_data[MISO_DATA_WIDTH];

    assign o_cfg_go      = r_go;
    assign o_cfg_done    = r_done;
    assign o_cfg_err     = r_err;
    assign o_tbl_addr    = r_addr;
    assign o_spi_wr_cmd  = r_wr_cmd;
    assign o_spi_rd_cmd  = r_rd_cmd;
    assign o_spi_wr_data = r_wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b1;
            r_start_qq  <= 1'b1;
            r_cnt       <= '0;
            r_seen_busy <= 1'b0;
            r_addr      <= '0;
            r_retry     <= '0;
            r_entry     <= '0;
            r_rd_data   <= '0;
            r_go        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wr_cmd    <= 1'b0;
            r_rd_cmd    <= 1'b0;
            r_wr_data   <= '0;
        end else begin
            r_state     <= w_state_n;
            r_start_q   <= i_cfg_start;
            r_start_qq  <= r_start_q;
            r_cnt       <= w_cnt_n;
            r_seen_busy <= w_seen_n;
            r_addr      <= w_addr_n;
            r_retry     <= w_retry_n;
            r_entry     <= w_entry_n;
            r_rd_data   <= w_rd_data_n;
            r_go        <= w_go_n;
            r_done      <= w_done_n;
            r_err       <= w_err_n;
            r_wr_cmd    <= w_wr_cmd_n;
            r_rd_cmd    <= w_rd_cmd_n;
            r_wr_data   <= w_wr_data_n;
        end
    end

    // The counter restarts from zero on every state change; each wait increments it explicitly.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = '0;
        w_seen_n    = r_seen_busy;
        w_addr_n    = r_addr;
        w_retry_n   = r_retry;
        w_entry_n   = r_entry;
        w_rd_data_n = r_rd_data;
        w_go_n      = r_go;
        w_done_n    = 1'b0;
        w_err_n     = r_err;
        w_wr_cmd_n  = 1'b0;
        w_rd_cmd_n  = 1'b0;
        w_wr_data_n = r_wr_data;

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_addr_n  = '0;
                    w_retry_n = '0;
                    w_err_n   = 1'b0;
                    w_go_n    = 1'b1;
                    w_state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                w_entry_n = i_tbl_entry;
                w_state_n = S_WR_CMD;
            end
            S_WR_CMD: begin
                if (!i_spi_busy) begin
                    w_wr_cmd_n  = 1'b1;
                    w_wr_data_n = {1'b0, r_entry[MOSI_DATA_WIDTH-2:0]};
                    w_seen_n    = 1'b0;
                    w_state_n   = S_WR_WAIT;
                end
            end
            S_WR_WAIT, S_RD_WAIT: begin
                if (!r_seen_busy) begin
                    if (i_spi_busy) begin
                        w_seen_n = 1'b1;
                    end else if (w_to_end) begin
                        w_state_n = S_FAIL;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end else if (!i_spi_busy) begin
                    if (r_state == S_WR_WAIT) begin
                        w_state_n = S_GAP_W;
                    end else begin
                        w_rd_data_n = i_spi_rd_data[MISO_DATA_WIDTH-1:0];
                        w_state_n   = S_CHECK;
                    end
                end
            end
            S_GAP_W: begin
                if (w_gap_end) begin
                    w_state_n = r_entry[MOSI_DATA_WIDTH-1] ? S_NEXT : S_RD_CMD;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_RD_CMD: begin
                if (!i_spi_busy) begin
                    w_rd_cmd_n  = 1'b1;
                    w_wr_data_n = {1'b1, r_entry[MOSI_DATA_WIDTH-2:MISO_DATA_WIDTH],
                                   {MISO_DATA_WIDTH{1'b0}}};
                    w_seen_n    = 1'b0;
                    w_state_n   = S_RD_WAIT;
                end
            end
            // A mismatch with retries left idles here for the gap, then rewrites the same entry.
            S_CHECK: begin
                if (w_match) begin
                    w_state_n = S_NEXT;
                end else if (int'(r_retry) < MAX_RETRY) begin
                    if (w_gap_end) begin
                        w_retry_n = r_retry + 1'b1;
                        w_state_n = S_WR_CMD;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end else begin
                    w_state_n = S_FAIL;
                end
            end
            S_NEXT: begin
                if (w_last) begin
                    w_state_n = S_DONE;
                end else if (w_gap_end) begin
                    w_addr_n  = r_addr + 1'b1;
                    w_retry_n = '0;
                    w_state_n = S_LOAD;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_done_n  = 1'b1;
                w_go_n    = 1'b0;
                w_state_n = S_IDLE;
            end
            S_FAIL: begin
                w_err_n   = 1'b1;
                w_go_n    = 1'b0;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_adc_reg_sequencer.sv
// Testbench for adc_reg_sequencer: SPI slave model with fault injection, a
// transaction-level expectation model and a per-cycle compare process.
module tb_adc_reg_sequencer;
    localparam int NREG = 4;
    localparam int MAXR = 3;
    localparam int GAPC = 16;
    localparam int BTO  = 1024;

    typedef struct {
        logic [23:0] frame;
        int          addr;
    } cmd_t;

    logic        clk;
    logic        rst;
    logic        i_cfg_start;
    logic        o_cfg_go;
    logic        o_cfg_done;
    logic        o_cfg_err;
    logic [1:0]  o_tbl_addr;
    logic [23:0] i_tbl_entry;
    logic        o_spi_wr_cmd;
    logic        o_spi_rd_cmd;
    logic [23:0] o_spi_wr_data;
    logic [8:0]  spiRdData;
    logic        spiBusy;

    logic [23:0] tbl [NREG];
    assign i_tbl_entry = tbl[o_tbl_addr];

    adc_reg_sequencer #(
        .MOSI_DATA_WIDTH(24),
        .MISO_DATA_WIDTH(8),
        .NUM_REGS(NREG),
        .MAX_RETRY(MAXR),
        .GAP_CYCLES(GAPC),
        .BUSY_TO(BTO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_cfg_start(i_cfg_start),
        .o_cfg_go(o_cfg_go),
        .o_cfg_done(o_cfg_done),
        .o_cfg_err(o_cfg_err),
        .o_tbl_addr(o_tbl_addr),
        .i_tbl_entry(i_tbl_entry),
        .o_spi_wr_cmd(o_spi_wr_cmd),
        .o_spi_rd_cmd(o_spi_rd_cmd),
        .o_spi_wr_data(o_spi_wr_data),
        .i_spi_rd_data(spiRdData),
        .i_spi_busy(spiBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wrCnt, rdCnt, wrA2Cnt, rd0ACnt, doneCnt;
    bit expFail;
    cmd_t expQ [$];

    logic [7:0]  mem [logic [14:0]];
    logic [14:0] corruptAddr;
    int          corruptLeft;
    bit          neverBusy;
    int          busyLeft;
    logic [8:0]  pendingRd;
    logic [14:0] mdlAddr;
    logic [7:0]  mdlVal;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // SPI slave: echoes written data, optionally corrupts readback or never raises busy
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            spiBusy  = 1'b0;
            busyLeft = 0;
        end else if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) begin
                spiBusy   = 1'b0;
                spiRdData = pendingRd;
            end
        end else if (!neverBusy && (o_spi_wr_cmd || o_spi_rd_cmd)) begin
            mdlAddr = o_spi_wr_data[22:8];
            if (o_spi_wr_cmd) begin
                mem[mdlAddr] = o_spi_wr_data[7:0];
            end else begin
                mdlVal = mem.exists(mdlAddr) ? mem[mdlAddr] : 8'h00;
                if (mdlAddr == corruptAddr && corruptLeft != 0) begin
                    mdlVal = 8'hFF;
                    if (corruptLeft > 0) corruptLeft--;
                end
                pendingRd = {1'b1, mdlVal};
            end
            spiBusy  = 1'b1;
            busyLeft = 4;
        end
    end

    // Expected command stream derived from the table and the injected faults
    task automatic buildExpect(input logic [14:0] cA, input int cN, input bit noBusy);
        int         left;
        int         tries;
        bit         fin;
        bit         corr;
        logic [7:0] rb;
        cmd_t       c;
        expQ.delete();
        expFail = 1'b0;
        left    = cN;
        for (int i = 0; i < NREG && !expFail; i++) begin
            tries = 0;
            fin   = 1'b0;
            while (!fin) begin
                c.frame = {1'b0, tbl[i][22:0]};
                c.addr  = i;
                expQ.push_back(c);
                if (noBusy) begin
                    expFail = 1'b1;
                    fin     = 1'b1;
                end else if (tbl[i][23]) begin
                    fin = 1'b1;
                end else begin
                    c.frame = {1'b1, tbl[i][22:8], 8'h00};
                    expQ.push_back(c);
                    corr = (tbl[i][22:8] == cA) && (left != 0);
                    if (corr && left > 0) left--;
                    rb = corr ? 8'hFF : tbl[i][7:0];
                    if (rb == tbl[i][7:0]) fin = 1'b1;
                    else if (tries == MAXR) begin
                        expFail = 1'b1;
                        fin     = 1'b1;
                    end else tries++;
                end
            end
        end
    endtask

    logic        prevBusy, prevCmd, prevErr;
    logic [23:0] prevData;

    always @(negedge clk) begin
        if (rst) begin
            prevBusy = 1'b0;
            prevCmd  = 1'b0;
            prevErr  = 1'b0;
            prevData = '0;
        end else begin
            if (o_spi_wr_cmd || o_spi_rd_cmd) begin
                checkOutput("cmd_exclusive", {31'b0, o_spi_wr_cmd & o_spi_rd_cmd}, 0);
                checkOutput("cmd_while_busy", {31'b0, prevBusy}, 0);
                checkOutput("cmd_one_cycle", {31'b0, prevCmd}, 0);
                checkOutput("cmd_expected", (expQ.size() > 0) ? 1 : 0, 1);
                if (expQ.size() > 0) begin
                    checkOutput("cmd_frame", {8'b0, o_spi_wr_data}, {8'b0, expQ[0].frame});
                    checkOutput("cmd_is_read", {31'b0, o_spi_rd_cmd}, {31'b0, expQ[0].frame[23]});
                    checkOutput("cmd_tbl_addr", {30'b0, o_tbl_addr}, expQ[0].addr);
                    void'(expQ.pop_front());
                end
                if (o_spi_wr_cmd) wrCnt++;
                if (o_spi_rd_cmd) rdCnt++;
                if (o_spi_wr_cmd && o_spi_wr_data[22:8] == 15'h0002) wrA2Cnt++;
                if (o_spi_rd_cmd && o_spi_wr_data[22:8] == 15'h000A) rd0ACnt++;
            end
            if (prevBusy && spiBusy)
                checkOutput("wr_data_hold", {8'b0, o_spi_wr_data}, {8'b0, prevData});
            if (o_cfg_done) begin
                doneCnt++;
                checkOutput("done_queue_empty", expQ.size(), 0);
                checkOutput("done_model_ok", {31'b0, expFail}, 0);
                checkOutput("done_go_low", {31'b0, o_cfg_go}, 0);
            end
            if (o_cfg_err && !prevErr) begin
                checkOutput("err_queue_empty", expQ.size(), 0);
                checkOutput("err_model_fail", {31'b0, expFail}, 1);
                checkOutput("err_go_low", {31'b0, o_cfg_go}, 0);
            end
            prevBusy = spiBusy;
            prevCmd  = o_spi_wr_cmd | o_spi_rd_cmd;
            prevErr  = o_cfg_err;
            prevData = o_spi_wr_data;
        end
    end

    task automatic applyStimulus(input logic [14:0] cA, input int cN, input int expW, input int expR,
                                 input int expA2, input int expDone, input int expErr, input bit latChk);
        int cyc;
        i_cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        corruptAddr = cA;
        corruptLeft = cN;
        neverBusy   = 1'b0;
        buildExpect(cA, cN, 1'b0);
        checkOutput("model_cmd_count", expQ.size(), expW + expR);
        checkOutput("model_outcome", {31'b0, expFail}, expErr);
        wrCnt = 0; rdCnt = 0; wrA2Cnt = 0; rd0ACnt = 0; doneCnt = 0;
        @(posedge clk);
        #1 i_cfg_start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_cfg_go && cyc < 10);
        checkOutput("go_rise", {31'b0, o_cfg_go}, 1);
        checkOutput("go_err_cleared", {31'b0, o_cfg_err}, 0);
        checkOutput("go_addr_zero", {30'b0, o_tbl_addr}, 0);
        if (latChk) begin
            checkOutput("go_latency", cyc, 3);
            @(negedge clk);
            checkOutput("lat_wr_cmd_n3", {31'b0, o_spi_wr_cmd}, 0);
            @(negedge clk);
            checkOutput("lat_wr_cmd_n4", {31'b0, o_spi_wr_cmd}, 1);
            checkOutput("lat_first_frame", {8'b0, o_spi_wr_data}, 32'h0000_0111);
        end
        cyc = 0;
        while (o_cfg_go && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        checkOutput("seq_ended", {31'b0, o_cfg_go}, 0);
        checkOutput("writes", wrCnt, expW);
        checkOutput("reads", rdCnt, expR);
        checkOutput("writes_reg2", wrA2Cnt, expA2);
        checkOutput("done_pulses", doneCnt, expDone);
        checkOutput("err_flag", {31'b0, o_cfg_err}, expErr);
        checkOutput("queue_drained", expQ.size(), 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_go"}, {31'b0, o_cfg_go}, 0);
        checkOutput({tag, "_done"}, {31'b0, o_cfg_done}, 0);
        checkOutput({tag, "_err"}, {31'b0, o_cfg_err}, 0);
        checkOutput({tag, "_addr"}, {30'b0, o_tbl_addr}, 0);
        checkOutput({tag, "_wr_cmd"}, {31'b0, o_spi_wr_cmd}, 0);
        checkOutput({tag, "_rd_cmd"}, {31'b0, o_spi_rd_cmd}, 0);
        checkOutput({tag, "_wr_data"}, {8'b0, o_spi_wr_data}, 0);
    endtask

    task automatic loadBaseTable();
        tbl[0] = 24'h00_01_11;
        tbl[1] = 24'h00_02_3C;
        tbl[2] = 24'h00_03_55;
        tbl[3] = 24'h00_04_AA;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int goSeen;
        rst         = 1'b1;
        i_cfg_start = 1'b0;
        spiBusy     = 1'b0;
        spiRdData   = '0;
        pendingRd   = '0;
        neverBusy   = 1'b0;
        corruptAddr = '0;
        corruptLeft = 0;
        busyLeft    = 0;
        loadBaseTable();
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        $display("[TB] all entries verify");
        applyStimulus(15'h0000, 0, 4, 4, 1, 1, 0, 1'b1);

        $display("[TB] entry 2 no-verify");
        tbl[2] = 24'h80_0A_5C;
        applyStimulus(15'h0000, 0, 4, 3, 1, 1, 0, 1'b0);
        checkOutput("no_read_0A", rd0ACnt, 0);
        loadBaseTable();

        $display("[TB] entry 1 mismatches twice");
        applyStimulus(15'h0002, 2, 6, 6, 3, 1, 0, 1'b0);

        $display("[TB] entry 1 mismatches permanently");
        applyStimulus(15'h0002, -1, 5, 5, 4, 0, 1, 1'b0);

        $display("[TB] busy never rises");
        i_cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        corruptLeft = 0;
        neverBusy   = 1'b1;
        buildExpect(15'h0000, 0, 1'b1);
        checkOutput("model_nobusy_count", expQ.size(), 1);
        doneCnt = 0;
        @(posedge clk);
        #1 i_cfg_start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_spi_wr_cmd && cyc < 20);
        checkOutput("nobusy_wr_cmd", {31'b0, o_spi_wr_cmd}, 1);
        repeat (BTO) @(negedge clk);
        checkOutput("nobusy_err_before_to", {31'b0, o_cfg_err}, 0);
        checkOutput("nobusy_go_before_to", {31'b0, o_cfg_go}, 1);
        @(negedge clk);
        #1;
        checkOutput("nobusy_err", {31'b0, o_cfg_err}, 1);
        checkOutput("nobusy_go", {31'b0, o_cfg_go}, 0);
        checkOutput("nobusy_no_done", doneCnt, 0);
        neverBusy = 1'b0;
        applyStimulus(15'h0000, 0, 4, 4, 1, 1, 0, 1'b0);

        $display("[TB] reset during read of entry 1");
        i_cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        corruptLeft = 0;
        buildExpect(15'h0000, 0, 1'b0);
        @(posedge clk);
        #1 i_cfg_start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(o_spi_rd_cmd && o_tbl_addr == 2'd1) && cyc < 500);
        checkOutput("rst_reach_rd1", {31'b0, (o_spi_rd_cmd && o_tbl_addr == 2'd1)}, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkReset("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        goSeen = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_cfg_go || o_spi_wr_cmd) goSeen++;
        end
        checkOutput("no_start_held_high", goSeen, 0);
        applyStimulus(15'h0000, 0, 4, 4, 1, 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
